// File: rtl/rand_timer_pkg.sv
// Shared types and constants for the randomized interval timer.
package rand_timer_pkg;

    typedef enum logic [1:0] {
        RIT_IDLE,
        RIT_LOAD,
        RIT_COUNT,
        RIT_WAIT_ACK
    } rit_state_t;

    localparam int RIT_DEF_WIDTH        = 10;
    localparam int RIT_DEF_MIN_INTERVAL = 16;

    // All-ones is the state an XNOR LFSR can never leave.
    localparam logic [RIT_DEF_WIDTH-1:0] RIT_LOCKUP_PATTERN = {RIT_DEF_WIDTH{1'b1}};

endpackage

// File: rtl/rit_down_counter.sv
// Loadable down-counter; clear beats load beats dec.
module rit_down_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      cnt <= '0;
        else if (clear) cnt <= '0;
        else if (load)  cnt <= load_val;
        else if (dec)   cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rand_interval_timer.sv
// Counts down rand_in + MIN_INTERVAL cycles, then holds fire until ack.
// Optional lock-up detection via `RIT_LOCKUP_DET_EN.
module rand_interval_timer
    import rand_timer_pkg::*;
#(
    parameter int WIDTH        = RIT_DEF_WIDTH,
    parameter int MIN_INTERVAL = RIT_DEF_MIN_INTERVAL,
    parameter int CNT_W        = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] rand_in,
    input  logic             ack,
    output logic             fire,
    output logic             busy,
    output logic [CNT_W-1:0] interval,
    output logic             lockup
);

    rit_state_t       state, state_nx;
    logic             cnt_load, cnt_clear, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] n_val;

    assign n_val = CNT_W'(rand_in) + CNT_W'(MIN_INTERVAL);

    rit_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (n_val - CNT_W'(1)),
        .clear    (cnt_clear),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nx  = state;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            RIT_IDLE: begin
                cnt_clear = 1'b1;
                if (enable) state_nx = RIT_LOAD;
            end
            RIT_LOAD: begin
                cnt_load = 1'b1;
                state_nx = RIT_COUNT;
            end
            RIT_COUNT: begin
                // An abort wins over expiry on the same edge.
                if (!enable) begin
                    cnt_clear = 1'b1;
                    state_nx  = RIT_IDLE;
                end else if (cnt_zero) begin
                    state_nx = RIT_WAIT_ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RIT_WAIT_ACK: begin
                if (ack) state_nx = enable ? RIT_LOAD : RIT_IDLE;
            end
            default: state_nx = RIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RIT_IDLE;
            fire     <= 1'b0;
            busy     <= 1'b0;
            interval <= '0;
        end else begin
            state <= state_nx;
            fire  <= (state_nx == RIT_WAIT_ACK);
            busy  <= (state_nx != RIT_IDLE);
            if (state == RIT_LOAD) interval <= n_val;
        end
    end

`ifdef RIT_LOCKUP_DET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lockup <= 1'b0;
        else if (state == RIT_LOAD && rand_in == WIDTH'(RIT_LOCKUP_PATTERN))
            lockup <= 1'b1;
    end
`else
    assign lockup = 1'b0;
`endif

endmodule

// File: tb/tb_rand_interval_timer.sv
// Bench for rand_interval_timer: timestamp-based reference model plus directed literal checks.
module tb_rand_interval_timer;

    localparam int WIDTH = 10;
    localparam int MINI  = 16;
    localparam int CNT_W = 11;
`ifdef RIT_LOCKUP_DET_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] rin = '0;
    logic             fire, busy, lockup;
    logic [CNT_W-1:0] interval;

    int total = 0;
    int bad   = 0;

    rand_interval_timer #(.WIDTH(WIDTH), .MIN_INTERVAL(MINI), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (rst),
        .enable   (en),
        .rand_in  (rin),
        .ack      (ack),
        .fire     (fire),
        .busy     (busy),
        .interval (interval),
        .lockup   (lockup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the edge number of the next sample and of the
    // next fire, rather than any state register.
    int n = 0, next_sample = -1, fire_edge = -1;
    bit m_fire = 0, m_busy = 0, m_lock = 0;
    int m_int = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0; next_sample = -1; fire_edge = -1;
            m_fire = 0; m_busy = 0; m_lock = 0; m_int = 0;
        end else begin
            n++;
            if (m_fire) begin
                if (ack) begin
                    m_fire = 0;
                    m_busy = en;
                    if (en) next_sample = n + 1;
                end
            end else if (next_sample == n) begin
                m_int = int'(rin) + MINI;
                fire_edge = n + m_int;
                next_sample = -1;
                if (LOCK_EN && rin == {WIDTH{1'b1}}) m_lock = 1;
            end else if (fire_edge >= 0) begin
                if (!en) begin
                    fire_edge = -1;
                    m_busy = 0;
                end else if (n == fire_edge) begin
                    m_fire = 1;
                    fire_edge = -1;
                end
            end else if (en) begin
                next_sample = n + 1;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("fire",     int'(fire),     int'(m_fire));
        chk("busy",     int'(busy),     int'(m_busy));
        chk("interval", int'(interval), m_int);
        chk("lockup",   int'(lockup),   int'(m_lock));
    end

    // Called at the negedge after the sample edge; returns edges until fire.
    task automatic edges_to_fire(input int bound, output int k);
        k = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (fire) begin
                k = i;
                break;
            end
        end
    endtask

    int k;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_fire", int'(fire), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_int",  int'(interval), 0);
        chk("reset_lock", int'(lockup), 0);
        rst = 1'b0;

        // rand_in = 0: interval 16, fire exactly 16 edges after sample
        en = 1'b1; rin = 10'h000;
        @(negedge clk); @(negedge clk);
        chk("int16", int'(interval), 16);
        chk("busy_load", int'(busy), 1);
        edges_to_fire(40, k);
        chk("lat16", k, 16);
        ack = 1'b1;
        @(negedge clk);
        chk("ack_fire_low", int'(fire), 0);
        chk("ack_busy_hi", int'(busy), 1);
        ack = 1'b0; rin = 10'h3FF;
        @(negedge clk);
        chk("int1039", int'(interval), 1039);
        chk("lock_3ff", int'(lockup), int'(LOCK_EN));
        rin = 10'h007;
        edges_to_fire(1100, k);
        chk("lat1039", k, 1039);

        // fire held with enable low and no ack
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_fire", int'(fire), 1);
        ack = 1'b1;
        @(negedge clk);
        chk("rel_fire", int'(fire), 0);
        chk("rel_busy", int'(busy), 0);
        ack = 1'b0;

        // abort at cnt=5
        en = 1'b1; rin = 10'd10;
        @(negedge clk); @(negedge clk);
        repeat (20) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        repeat (30) @(negedge clk);
        chk("abort_nofire", int'(fire), 0);

        // ack pulse during COUNT is ignored
        en = 1'b1; rin = 10'd2;
        @(negedge clk); @(negedge clk);
        chk("int18", int'(interval), 18);
        repeat (4) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        edges_to_fire(40, k);
        chk("lat18_ack", k + 5, 18);
        chk("lock_sticky", int'(lockup), int'(LOCK_EN));
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // async reset mid-count
        rin = 10'h005;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_fire", int'(fire), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_int",  int'(interval), 0);
        chk("arst_lock", int'(lockup), 0);
        @(negedge clk);
        rst = 1'b0; rin = 10'd9;
        @(negedge clk); @(negedge clk);
        chk("int25_after_rst", int'(interval), 25);

        // randomized phase
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) en = ~en;
            ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) rin = 10'h3FF;
            else rin = WIDTH'($urandom_range(0, 63));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rand_interval_timer.md
# rand_interval_timer

Randomized interval timer fed directly by the 10-bit LFSR output. It samples the LFSR word and counts down an interval of `rand_in + MIN_INTERVAL` cycles. At expiry it raises `fire` and holds it until the consumer acknowledges. It is the consumer stage that turns the free-running pseudo-random sequence into pseudo-random event timing (stimulus injection, randomized stalls).

## Interface
- `WIDTH`, 10, width of `rand_in`; matches LFSR output width
- `MIN_INTERVAL`, 16, constant added to every sampled value; must be ≥1
- `CNT_W`, 11, counter/interval width; must hold `2^WIDTH-1 + MIN_INTERVAL`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `enable`  in  1  arm the timer; low aborts a count in progress
- `rand_in`  in  WIDTH  LFSR output word
- `ack`  in  1  consumer acknowledge; only honoured while `fire`=1
- `fire`  out  1  interval expired; level, held until `ack`
- `busy`  out  1  high in LOAD, COUNT or WAIT_ACK
- `interval`  out  CNT_W  last loaded interval N = `rand_in + MIN_INTERVAL`
- `lockup`  out  1  sticky LFSR lock-up flag (see Configuration)

## Operation
- States: IDLE, LOAD, COUNT, WAIT_ACK.
- IDLE: counter held at 0. If `enable`=1, go to LOAD.
- LOAD: sample `rand_in`. Set `interval` <= zero-extended `rand_in + MIN_INTERVAL`. Set `cnt` <= N-1. Go to COUNT. Unsigned arithmetic in CNT_W bits; no overflow by parameter rule.
- COUNT:
  - `enable`=0: go to IDLE and clear `cnt`; `interval` is retained.
  - `cnt`=0: go to WAIT_ACK and set `fire`=1.
  - Otherwise decrement `cnt`.
- WAIT_ACK: `fire` held at 1 regardless of `enable`.
  - `ack`=1: clear `fire`; go to LOAD if `enable`=1, else IDLE.
- `ack` while `fire`=0 is ignored.
- `enable` and `ack` both low in WAIT_ACK: remain there indefinitely.
- Reset (async, any state, including mid-count): state IDLE; `fire`=0, `busy`=0, `interval`=0, `lockup`=0, `cnt`=0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Edge E is the clock edge leaving LOAD (where `rand_in` is sampled). `fire` rises on edge E+N, so the interval is exactly N cycles.
- `ack` sampled high on edge A: `fire` low after A. If `enable`=1, `rand_in` is sampled on A+1 and the next `fire` rises on A+1+N'.
- IDLE→LOAD costs one edge: `enable` rising before edge S gives the sample on S+1.
- `interval` and `lockup` update on the LOAD edge.
- `busy` tracks state, registered.
- Minimum `fire` high time: 1 cycle, when `ack` is already high at the first high edge.

## Configuration
- `RIT_LOCKUP_DET_EN` defined:
  - In LOAD, `rand_in` == all ones (10'h3FF, the XNOR-LFSR lock-up state) sets `lockup`=1, sticky until reset.
  - The interval is still loaded and used normally.
- Undefined: `lockup` tied 0; 10'h3FF is treated as an ordinary sample.

## Structure
- Package `rand_timer_pkg`:
  - state enum `rit_state_t`
  - `RIT_LOCKUP_PATTERN` constant (all ones, WIDTH bits)
  - default `MIN_INTERVAL`
- One sub-module, `rit_down_counter`: CNT_W loadable down-counter with `load`, `clear`, `dec` and `zero` outputs, async active-high reset. The FSM stays in the top.

## Test plan
- Reset mid-COUNT (`rand_in`=10'h005): assert `reset` asynchronously → all outputs 0 immediately, state IDLE; after release with `enable`=1, the next LOAD samples afresh.
- `enable`=1, `rand_in`=10'h000, MIN_INTERVAL=16 → `interval`=16, `fire` rises exactly 16 edges after the LOAD edge; `ack` pulse → `fire` falls next edge, re-LOAD on the following edge.
- `rand_in`=10'h3FF → `interval`=1039, `fire` at E+1039. With `RIT_LOCKUP_DET_EN`: `lockup`=1 from the LOAD edge and stays 1 through later non-3FF samples. Without it: `lockup` stays 0.
- Drop `enable` at cnt=5 → IDLE, `busy`=0, `fire` never asserts; re-raise `enable` → new sample, full new interval.
- `fire` high, `enable` dropped, `ack` held low 20 cycles → `fire` stays 1. Then `ack`=1 → `fire`=0, state IDLE, `busy`=0.
- `ack` pulsed during COUNT → ignored; `fire` timing unchanged.
